// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - control-flow sequencer for a 1-bit controller.
// Handles JMP/RTN return stack, SKZ skipping, IEN/OEN gating and decode pulses.
module mc_sequencer #(
  parameter int SIZE_LOG    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          instr,
  input  logic [SIZE_LOG-1:0] pc_in,
  input  logic [SIZE_LOG-1:0] jump_addr,
  input  logic                rr,
  input  logic                data_in,
  output logic                pc_write,
  output logic [SIZE_LOG-1:0] pc_target,
  output logic                skip,
  output logic                ien,
  output logic                oen,
  output logic                write_en,
  output logic                jmp_o,
  output logic                rtn_o,
  output logic                flag_o,
  output logic                flag_f,
  output logic                stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
    OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
    OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
    OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
  } opcode_t;

  opcode_t             op;
  logic                active;
  logic [SIZE_LOG-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]    sp;
  logic [CNT_W-1:0]    count;
  logic                stack_empty;
  logic                stack_full;
  logic [SIZE_LOG-1:0] stack_top;

  assign op          = opcode_t'(instr);
  assign active      = ~rst & ~skip;
  assign stack_empty = (count == '0);
  assign stack_full  = (count == CNT_W'(STACK_DEPTH));
  // sp points at the next free slot, so the top is one below it
  assign stack_top   = stack_mem[sp - PTR_W'(1)];

  always_comb begin
    pc_write  = 1'b0;
    pc_target = '0;
    write_en  = 1'b0;
    jmp_o     = 1'b0;
    rtn_o     = 1'b0;
    flag_o    = 1'b0;
    flag_f    = 1'b0;
    if (active) begin
      case (op)
        OP_JMP: begin
          pc_write  = 1'b1;
          pc_target = jump_addr;
          jmp_o     = 1'b1;
        end
        OP_RTN: begin
          rtn_o = 1'b1;
          if (!stack_empty) begin
            pc_write  = 1'b1;
            pc_target = stack_top;
          end
        end
        OP_STO, OP_STOC: write_en = oen;
        OP_NOPO:         flag_o   = 1'b1;
        OP_NOPF:         flag_f   = 1'b1;
        default: ;
      endcase
    end
  end

  // Entry contents need no reset: they are only read while count is nonzero
  always_ff @(posedge clk) begin
    if (active && op == OP_JMP)
      stack_mem[sp] <= pc_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip      <= 1'b0;
      ien       <= 1'b0;
      oen       <= 1'b0;
      stack_err <= 1'b0;
      sp        <= '0;
      count     <= '0;
    end else if (skip) begin
      skip <= 1'b0;
    end else begin
      case (op)
        OP_JMP: begin
          // a full stack wraps onto its oldest entry
          sp <= sp + PTR_W'(1);
          if (stack_full) stack_err <= 1'b1;
          else            count     <= count + CNT_W'(1);
        end
        OP_RTN: begin
          skip <= 1'b1;
          if (stack_empty) begin
            stack_err <= 1'b1;
          end else begin
            sp    <= sp - PTR_W'(1);
            count <= count - CNT_W'(1);
          end
        end
        OP_SKZ: skip <= ~rr;
        OP_IEN: ien  <= data_in;
        OP_OEN: oen  <= data_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - scoreboard bench for mc_sequencer.
module tb_mc_sequencer;

  localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, AND_ = 4'h3, XNOR_ = 4'h7,
                         STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB,
                         JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] instr = LD;
  logic [7:0] pc_in = '0;
  logic [7:0] jump_addr = '0;
  logic       rr = 1'b0;
  logic       data_in = 1'b0;
  logic       pc_write, skip, ien, oen, write_en;
  logic       jmp_o, rtn_o, flag_o, flag_f, stack_err;
  logic [7:0] pc_target;

  int checks = 0;
  int errors = 0;

  // {pc_write, pc_target, write_en, jmp_o, rtn_o, flag_o, flag_f, skip, ien, oen, stack_err}
  logic [17:0] exp_q [$];
  string       name_q [$];

  mc_sequencer #(.SIZE_LOG(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .jump_addr(jump_addr),
    .rr(rr), .data_in(data_in), .pc_write(pc_write), .pc_target(pc_target),
    .skip(skip), .ien(ien), .oen(oen), .write_en(write_en), .jmp_o(jmp_o),
    .rtn_o(rtn_o), .flag_o(flag_o), .flag_f(flag_f), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic pw, input logic [7:0] tgt,
      input logic we, input logic j, input logic r, input logic fo, input logic ff,
      input logic s, input logic i, input logic o, input logic e);
    return {pw, tgt, we, j, r, fo, ff, s, i, o, e};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] got, want;
      string nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {pc_write, pc_target, write_en, jmp_o, rtn_o, flag_o, flag_f,
              skip, ien, oen, stack_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, want);
      end
    end
  end

  task automatic step(input string nm, input logic [3:0] op, input logic [7:0] pc,
                      input logic [7:0] ja, input logic r_in, input logic d_in,
                      input logic [17:0] e);
    @(posedge clk); #1;
    instr = op; pc_in = pc; jump_addr = ja; rr = r_in; data_in = d_in;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Async reset pulse between edges; a JMP on instr must be masked
  task automatic pulse_reset(input string nm);
    @(posedge clk); #1;
    instr = JMP; pc_in = 8'h77; jump_addr = 8'h66; rst = 1'b1;
    exp_q.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    name_q.push_back(nm);
    @(negedge clk); #2;
    instr = LD;
    rst = 1'b0;
  endtask

  initial begin
    pulse_reset("reset_state");

    // JMP/RTN round trip and skipped return slot
    step("jmp_10_40",   JMP,  8'h10, 8'h40, 0, 0, mk(1, 8'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step("nopo",        NOPO, 8'h40, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("rtn_to_10",   RTN,  8'h41, 8'h00, 0, 0, mk(1, 8'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("jmp_skipped", JMP,  8'h10, 8'h40, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step("nopf",        NOPF, 8'h11, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // OEN, SKZ, STO/STOC gating, IEN
    step("oen_1",       OEN,  8'h12, 8'h00, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("sto_oen1",    STO,  8'h13, 8'h00, 0, 0, mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("skz_rr0",     SKZ,  8'h14, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("sto_skipped", STO,  8'h15, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step("after_skip",  NOPO, 8'h16, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    step("skz_rr1",     SKZ,  8'h17, 8'h00, 1, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("sto_noskip",  STO,  8'h18, 8'h00, 0, 0, mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("oen_0",       OEN,  8'h19, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("stoc_oen0",   STOC, 8'h1A, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("oen_1b",      OEN,  8'h1B, 8'h00, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("stoc_oen1",   STOC, 8'h1C, 8'h00, 0, 0, mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("ien_1",       IEN,  8'h1D, 8'h00, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("ld_quiet",    LD,   8'h1E, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("and_quiet",   AND_, 8'h1F, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("xnor_quiet",  XNOR_,8'h20, 8'h00, 1, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("skz_rr0_b",   SKZ,  8'h21, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("ien_skipped", IEN,  8'h22, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    step("ien_held",    NOPO, 8'h23, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 1, 0));

    // Overflow: five pushes into a four-deep stack
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] pc_k, ja_k;
      pc_k = 8'(k);
      ja_k = 8'(8'h30 + k);
      step($sformatf("jmp_push_%0d", k), JMP, pc_k, ja_k, 0, 0,
           mk(1, ja_k, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    end
    step("rtn_05",      RTN,  8'h35, 8'h00, 0, 0, mk(1, 8'h05, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    step("skip_a",      NOPO, 8'h06, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    step("rtn_04",      RTN,  8'h07, 8'h00, 0, 0, mk(1, 8'h04, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    step("skip_b",      NOPO, 8'h05, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    step("rtn_03",      RTN,  8'h06, 8'h00, 0, 0, mk(1, 8'h03, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    step("skip_c",      NOPO, 8'h04, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    step("rtn_02",      RTN,  8'h05, 8'h00, 0, 0, mk(1, 8'h02, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    step("skip_jmp",    JMP,  8'h03, 8'h99, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    step("rtn_empty",   RTN,  8'h04, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    step("skip_d",      NOPF, 8'h05, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 1));

    // RTN right after reset
    pulse_reset("reset_clears");
    step("rtn_post_rst",RTN,  8'h08, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("rtn_err_set", NOPO, 8'h09, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    // Reset between a JMP pair and their RTN discards the stack
    step("oen_set",     OEN,  8'h0A, 8'h00, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("jmp_pair_a",  JMP,  8'h10, 8'h50, 0, 0, mk(1, 8'h50, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    step("jmp_pair_b",  JMP,  8'h11, 8'h51, 0, 0, mk(1, 8'h51, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    step("skz_pre_rst", SKZ,  8'h12, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    pulse_reset("mid_reset");
    step("rtn_after",   RTN,  8'h13, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("rtn_after_sk",NOPO, 8'h14, 8'h00, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter SIZE_LOG, default 8, meaning program address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-stack entries (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all internal registers update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port instr, input, 4 bits: current opcode (0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF).
REQ-006 SHALL have port pc_in, input, SIZE_LOG bits: address of the current instruction, from the program counter.
REQ-007 SHALL have port jump_addr, input, SIZE_LOG bits: operand address field of the current instruction.
REQ-008 SHALL have port rr, input, 1 bit: current result-register value.
REQ-009 SHALL have port data_in, input, 1 bit: data-bus bit, used by IEN and OEN.
REQ-010 SHALL have port pc_write, output, 1 bit: program-counter load request.
REQ-011 SHALL have port pc_target, output, SIZE_LOG bits: program-counter load address.
REQ-012 SHALL have ports skip, ien and oen, each an output of 1 bit: registered state.
REQ-013 SHALL have port write_en, output, 1 bit: data-store strobe.
REQ-014 SHALL have ports jmp_o, rtn_o, flag_o and flag_f, each an output of 1 bit: decode pulses.
REQ-015 SHALL have port stack_err, output, 1 bit: sticky flag for return-stack overflow or underflow.

Function
REQ-016 SHALL treat the instruction on instr as active when skip = 0, and as suppressed when skip = 1.
REQ-017 SHALL, for a suppressed instruction, hold every combinational output at 0, leave the stack, ien, oen and stack_err unchanged, and clear skip at the next rising edge.
REQ-018 SHALL drive pc_write, pc_target, write_en, jmp_o, rtn_o, flag_o and flag_f combinationally from instr and the current state, so the program counter (falling-edge) samples them in the same cycle.
REQ-019 SHALL hold pc_target at 0 whenever pc_write = 0.
REQ-020 SHALL, for active JMP: pc_write = 1, pc_target = jump_addr, jmp_o = 1; push pc_in onto the return stack at the rising edge.
REQ-021 SHALL, for active JMP with the stack full: discard the oldest entry, push pc_in, keep the count at STACK_DEPTH, and set stack_err.
REQ-022 SHALL, for active RTN with the stack non-empty: pc_write = 1, pc_target = top entry, rtn_o = 1; pop the entry and set skip at the rising edge, so the stored JMP is skipped.
REQ-023 SHALL, for active RTN with the stack empty: pc_write = 0, rtn_o = 1; set skip and stack_err at the rising edge.
REQ-024 SHALL, for active SKZ: skip <= 1 if rr = 0, otherwise skip <= 0.
REQ-025 SHALL, for active IEN: ien <= data_in; for active OEN: oen <= data_in.
REQ-026 SHALL, for active STO or STOC: write_en = oen.
REQ-027 SHALL assert flag_o for active NOPO and flag_f for active NOPF, for exactly that cycle.
REQ-028 SHALL produce no outputs and no state change (skip stays 0) for active opcodes 1 to 7, which are datapath-only.
REQ-029 SHALL wrap the stack pointer modulo STACK_DEPTH and saturate the entry count in the range 0..STACK_DEPTH.
REQ-030 SHALL keep stack_err at 1 once set, until reset.

Reset
REQ-031 SHALL, while rst = 1 and independent of clk, force skip, ien, oen and stack_err to 0, the stack count to 0, and the stack pointer to 0.
REQ-032 SHALL force all combinational outputs to 0 while rst = 1.
REQ-033 SHALL, when rst is asserted mid-sequence (for example between a JMP and its RTN), discard all stack contents, so that a later RTN behaves as an empty-stack RTN.
REQ-034 SHALL leave stack entry contents unspecified after reset; they are never observable while the count is 0.

Verification
REQ-035 SHALL cover: pc_in = 0x10, instr = C, jump_addr = 0x40 -> pc_write = 1, pc_target = 0x40, jmp_o = 1; a later RTN -> pc_target = 0x10, skip = 1 in the next cycle, and the next instruction is suppressed.
REQ-036 SHALL cover: SKZ with rr = 0, then STO with oen = 1 -> write_en = 0 and skip = 0 afterwards; SKZ with rr = 1, then STO -> write_en = 1.
REQ-037 SHALL cover: 5 JMPs from 0x01..0x05 with STACK_DEPTH = 4 -> stack_err = 1; 4 RTNs return 0x05, 0x04, 0x03, 0x02; a 5th RTN -> pc_write = 0.
REQ-038 SHALL cover: RTN immediately after reset -> pc_write = 0, rtn_o = 1, then skip = 1 and stack_err = 1.
REQ-039 SHALL cover: OEN with data_in = 0, then STOC -> write_en = 0; OEN with data_in = 1, then STOC -> write_en = 1; IEN with data_in = 1 -> ien = 1.
REQ-040 SHALL cover: rst pulsed asynchronously between clock edges after two JMPs -> skip, oen and stack_err read 0 immediately, and the following RTN -> pc_write = 0.
